// File: rtl/ap_cam_engine_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ap_pkg
//  Description : Shared definitions for the associative-processing engine:
//                opcodes, per-op pass counts, FSM state encoding and the
//                pass-table entry format.
//  Revision    : 1.0 - initial release
// ============================================================================
package ap_pkg;

    // Opcodes presented on the op port
    localparam logic [2:0] C_OP_ADD     = 3'd0;
    localparam logic [2:0] C_OP_SUB     = 3'd1;
    localparam logic [2:0] C_OP_AND     = 3'd2;
    localparam logic [2:0] C_OP_OR      = 3'd3;
    localparam logic [2:0] C_OP_XOR     = 3'd4;
    localparam logic [2:0] C_OP_COPY_A  = 3'd5;
    localparam logic [2:0] C_OP_SEARCH  = 3'd6;
    localparam logic [2:0] C_OP_ILLEGAL = 3'd7;

    // Sequencer states
    localparam logic [2:0] C_ST_IDLE = 3'd0;
    localparam logic [2:0] C_ST_INIT = 3'd1;
    localparam logic [2:0] C_ST_CMP  = 3'd2;
    localparam logic [2:0] C_ST_WR   = 3'd3;
    localparam logic [2:0] C_ST_SRCH = 3'd4;
    localparam logic [2:0] C_ST_DONE = 3'd5;

    // One pass: compare {C,A,B'} against key where keymask=1, then write the
    // tagged rows (R bit set and/or carry column update).
    typedef struct packed {
        logic [2:0] key;
        logic [2:0] keymask;
        logic       wr_r;
        logic       wr_c_en;
        logic       wr_c_val;
    } pass_entry_t;

    // Passes per bit column for each op; non-pass ops return 1 so the
    // last-pass compare is always well defined.
    function automatic logic [2:0] npass(input logic [2:0] op);
        case (op)
            C_OP_ADD, C_OP_SUB: npass = 3'd6;
            C_OP_OR:            npass = 3'd3;
            C_OP_XOR:           npass = 3'd2;
            default:            npass = 3'd1;
        endcase
    endfunction

    function automatic pass_entry_t mk_pass(input logic [2:0] key, input logic [2:0] keymask,
                                            input logic wr_r, input logic wr_c_en,
                                            input logic wr_c_val);
        mk_pass = '{key: key, keymask: keymask, wr_r: wr_r,
                    wr_c_en: wr_c_en, wr_c_val: wr_c_val};
    endfunction

endpackage
`default_nettype wire

// File: rtl/ap_cam_engine_if.sv
`default_nettype none
// ============================================================================
//  Module      : ap_cam_engine_if
//  Description : Controller handshake, host row port and result bus of the
//                associative-processing engine.
//                master : controller/host side (drives start/op/key/mask,
//                         wr_*, rd_sel/rd_addr)
//                slave  : engine side (drives busy/done/err, rd_data,
//                         carry_out, match_vec/any/idx)
//  Revision    : 1.0 - initial release
// ============================================================================
interface ap_cam_engine_if #(
    parameter int DATA_WIDTH     = 8,
    parameter int DATA_DEPTH     = 16,
    parameter int ADDR_WIDTH_CAM = 4
);
    logic                      start;
    logic [2:0]                op;
    logic [DATA_WIDTH-1:0]     key;
    logic [DATA_WIDTH-1:0]     mask;
    logic                      busy;
    logic                      done;
    logic                      err;
    logic                      wr_en;
    logic                      wr_sel;
    logic [ADDR_WIDTH_CAM-1:0] wr_addr;
    logic [DATA_WIDTH-1:0]     wr_data;
    logic [1:0]                rd_sel;
    logic [ADDR_WIDTH_CAM-1:0] rd_addr;
    logic [DATA_WIDTH-1:0]     rd_data;
    logic [DATA_DEPTH-1:0]     carry_out;
    logic [DATA_DEPTH-1:0]     match_vec;
    logic                      match_any;
    logic [ADDR_WIDTH_CAM-1:0] match_idx;

    modport master (
        output start, op, key, mask, wr_en, wr_sel, wr_addr, wr_data, rd_sel, rd_addr,
        input  busy, done, err, rd_data, carry_out, match_vec, match_any, match_idx
    );

    modport slave (
        input  start, op, key, mask, wr_en, wr_sel, wr_addr, wr_data, rd_sel, rd_addr,
        output busy, done, err, rd_data, carry_out, match_vec, match_any, match_idx
    );
endinterface
`default_nettype wire

// File: rtl/ap_cam_engine_pass_rom.sv
`default_nettype none
// ============================================================================
//  Module      : ap_pass_rom
//  Description : Combinational pass table: (op, pass index) -> pass entry.
//                Ports: i_op (latched opcode), i_pass (pass index),
//                       o_entry (key, keymask and write action).
//  Revision    : 1.0 - initial release
// ============================================================================
module ap_pass_rom
    import ap_pkg::*;
(
    input  wire logic [2:0] i_op,
    input  wire logic [2:0] i_pass,
    output pass_entry_t     o_entry
);

    always_comb begin
        o_entry = '0;
        case (i_op)
            // Four sum passes first so every sum bit sees the old carry,
            // then the two carry updates (majority function).
            C_OP_ADD, C_OP_SUB: begin
                case (i_pass)
                    3'd0:    o_entry = mk_pass(3'b001, 3'b111, 1'b1, 1'b0, 1'b0);
                    3'd1:    o_entry = mk_pass(3'b010, 3'b111, 1'b1, 1'b0, 1'b0);
                    3'd2:    o_entry = mk_pass(3'b100, 3'b111, 1'b1, 1'b0, 1'b0);
                    3'd3:    o_entry = mk_pass(3'b111, 3'b111, 1'b1, 1'b0, 1'b0);
                    3'd4:    o_entry = mk_pass(3'b100, 3'b111, 1'b0, 1'b1, 1'b0);
                    3'd5:    o_entry = mk_pass(3'b011, 3'b111, 1'b0, 1'b1, 1'b1);
                    default: o_entry = '0;
                endcase
            end
            C_OP_AND:    o_entry = mk_pass(3'b011, 3'b011, 1'b1, 1'b0, 1'b0);
            C_OP_OR: begin
                case (i_pass)
                    3'd0:    o_entry = mk_pass(3'b010, 3'b011, 1'b1, 1'b0, 1'b0);
                    3'd1:    o_entry = mk_pass(3'b001, 3'b011, 1'b1, 1'b0, 1'b0);
                    default: o_entry = mk_pass(3'b011, 3'b011, 1'b1, 1'b0, 1'b0);
                endcase
            end
            C_OP_XOR: begin
                if (i_pass == 3'd0) o_entry = mk_pass(3'b010, 3'b011, 1'b1, 1'b0, 1'b0);
                else                o_entry = mk_pass(3'b001, 3'b011, 1'b1, 1'b0, 1'b0);
            end
            C_OP_COPY_A: o_entry = mk_pass(3'b010, 3'b010, 1'b1, 1'b0, 1'b0);
            default:     o_entry = '0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/ap_cam_engine.sv
`default_nettype none
// ============================================================================
//  Module      : ap_cam_engine
//  Description : Bit-serial associative-processing engine. Holds operand
//                arrays A/B, result array R, carry column C and tag column;
//                runs ADD/SUB/AND/OR/XOR/COPY_A as compare/write pass pairs
//                over all rows in parallel, plus a single-cycle masked SEARCH.
//                Ports: clk, rst (sync, active high),
//                       bus (ap_cam_engine_if.slave: start/op/key/mask,
//                       busy/done/err, host write/read row port,
//                       carry_out, match_vec/any/idx).
//  Revision    : 1.0 - initial release
// ============================================================================
module ap_cam_engine
    import ap_pkg::*;
#(
    parameter int DATA_WIDTH     = 8,
    parameter int DATA_DEPTH     = 16,
    parameter int ADDR_WIDTH_CAM = 4
) (
    input  wire logic        clk,
    input  wire logic        rst,
    ap_cam_engine_if.slave   bus
);

    localparam int C_BIT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    logic [2:0]                r_state;
    logic [2:0]                r_op;
    logic [DATA_WIDTH-1:0]     r_key;
    logic [DATA_WIDTH-1:0]     r_mask;
    logic [C_BIT_W-1:0]        r_bit;
    logic [2:0]                r_pass;
    logic [DATA_WIDTH-1:0]     r_a [DATA_DEPTH];
    logic [DATA_WIDTH-1:0]     r_b [DATA_DEPTH];
    logic [DATA_WIDTH-1:0]     r_r [DATA_DEPTH];
    logic [DATA_DEPTH-1:0]     r_c;
    logic [DATA_DEPTH-1:0]     r_tag;
    logic [DATA_DEPTH-1:0]     r_match;
    logic [DATA_WIDTH-1:0]     r_rd_data;

    pass_entry_t               w_entry;
    logic [DATA_DEPTH-1:0]     w_hit;
    logic [DATA_DEPTH-1:0]     w_srch;
    logic                      w_last_pass;
    logic                      w_last_bit;
    logic [ADDR_WIDTH_CAM-1:0] w_idx;

    ap_pass_rom u_pass_rom (
        .i_op    (r_op),
        .i_pass  (r_pass),
        .o_entry (w_entry)
    );

    assign w_last_pass = (r_pass == npass(r_op) - 3'd1);
    assign w_last_bit  = (r_bit == C_BIT_W'(DATA_WIDTH - 1));

    // Per-row compare of the current bit slice and the full-word search.
    for (genvar gi = 0; gi < DATA_DEPTH; gi++) begin : g_row
        logic       w_b_bit;
        logic [2:0] w_cab;
        // SUB runs the adder on ~B with carry preset to 1 (two's complement).
        assign w_b_bit    = (r_op == C_OP_SUB) ? ~r_b[gi][r_bit] : r_b[gi][r_bit];
        assign w_cab      = {r_c[gi], r_a[gi][r_bit], w_b_bit};
        assign w_hit[gi]  = ((w_cab ^ w_entry.key) & w_entry.keymask) == 3'b000;
        assign w_srch[gi] = &(~(r_a[gi] ^ r_key) | ~r_mask);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= C_ST_IDLE;
            r_op      <= '0;
            r_key     <= '0;
            r_mask    <= '0;
            r_bit     <= '0;
            r_pass    <= '0;
            r_c       <= '0;
            r_tag     <= '0;
            r_match   <= '0;
            r_rd_data <= '0;
            for (int r = 0; r < DATA_DEPTH; r++) begin
                r_a[r] <= '0;
                r_b[r] <= '0;
                r_r[r] <= '0;
            end
        end else begin
            case (bus.rd_sel)
                2'd0:    r_rd_data <= r_a[bus.rd_addr];
                2'd1:    r_rd_data <= r_b[bus.rd_addr];
                2'd2:    r_rd_data <= r_r[bus.rd_addr];
                default: r_rd_data <= '0;
            endcase

            // Host writes land on the acceptance edge too, so the op that
            // starts in the same cycle already sees them.
            if (r_state == C_ST_IDLE && bus.wr_en) begin
                if (bus.wr_sel) r_b[bus.wr_addr] <= bus.wr_data;
                else            r_a[bus.wr_addr] <= bus.wr_data;
            end

            case (r_state)
                C_ST_IDLE: begin
                    if (bus.start) begin
                        r_op    <= bus.op;
                        r_key   <= bus.key;
                        r_mask  <= bus.mask;
                        r_bit   <= '0;
                        r_pass  <= '0;
                        r_state <= C_ST_INIT;
                    end
                end
                C_ST_INIT: begin
                    case (r_op)
                        C_OP_SEARCH:  r_state <= C_ST_SRCH;
                        C_OP_ILLEGAL: r_state <= C_ST_DONE;
                        default: begin
                            for (int r = 0; r < DATA_DEPTH; r++) r_r[r] <= '0;
                            r_c     <= (r_op == C_OP_SUB) ? '1 : '0;
                            r_state <= C_ST_CMP;
                        end
                    endcase
                end
                C_ST_CMP: begin
                    r_tag   <= w_hit;
                    r_state <= C_ST_WR;
                end
                C_ST_WR: begin
                    for (int r = 0; r < DATA_DEPTH; r++) begin
                        if (r_tag[r]) begin
                            if (w_entry.wr_r)    r_r[r][r_bit] <= 1'b1;
                            if (w_entry.wr_c_en) r_c[r]        <= w_entry.wr_c_val;
                        end
                    end
                    if (w_last_pass) begin
                        r_pass <= '0;
                        if (w_last_bit) begin
                            r_state <= C_ST_DONE;
                        end else begin
                            r_bit   <= r_bit + C_BIT_W'(1);
                            r_state <= C_ST_CMP;
                        end
                    end else begin
                        r_pass  <= r_pass + 3'd1;
                        r_state <= C_ST_CMP;
                    end
                end
                C_ST_SRCH: begin
                    r_match <= w_srch;
                    r_state <= C_ST_DONE;
                end
                C_ST_DONE: r_state <= C_ST_IDLE;
                default:   r_state <= C_ST_IDLE;
            endcase
        end
    end

    // Lowest matching row wins: scan from the top so lower rows overwrite.
    always_comb begin
        w_idx = '0;
        for (int r = DATA_DEPTH - 1; r >= 0; r--) begin
            if (r_match[r]) w_idx = ADDR_WIDTH_CAM'(r);
        end
    end

    assign bus.busy      = (r_state != C_ST_IDLE);
    assign bus.done      = (r_state == C_ST_DONE);
    assign bus.err       = (r_state == C_ST_DONE) && (r_op == C_OP_ILLEGAL);
    assign bus.rd_data   = r_rd_data;
    assign bus.carry_out = r_c;
    assign bus.match_vec = r_match;
    assign bus.match_any = |r_match;
    assign bus.match_idx = w_idx;

endmodule
`default_nettype wire

// File: tb/tb_ap_cam_engine.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ap_cam_engine
//  Description : Scoreboard bench for ap_cam_engine. Stimulus pushes expected
//                op completions and read data into queues; a monitor pops
//                and compares when done pulses or read data returns.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_ap_cam_engine;

    localparam int W  = 8;
    localparam int D  = 16;
    localparam int AW = 4;

    typedef struct packed {
        logic [63:0]  done_cyc;
        logic         err;
        logic [D-1:0] c;
        logic [D-1:0] mvec;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    ap_cam_engine_if #(.DATA_WIDTH(W), .DATA_DEPTH(D), .ADDR_WIDTH_CAM(AW)) bus ();

    ap_cam_engine #(.DATA_WIDTH(W), .DATA_DEPTH(D), .ADDR_WIDTH_CAM(AW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Reference state
    logic [W-1:0] ma [D];
    logic [W-1:0] mb [D];
    logic [W-1:0] mr [D];
    logic [D-1:0] mc;
    logic [D-1:0] mm;

    exp_t         expq [$];
    logic [W-1:0] rdq  [$];

    int           n_checks   = 0;
    int           n_fail     = 0;
    int           ops_issued = 0;
    int           ops_done   = 0;
    logic [63:0]  cyc        = 0;
    logic [63:0]  last_start = 0;
    logic         rd_issue   = 1'b0;
    logic         rd_chk     = 1'b0;
    exp_t         mon_x;
    logic [W-1:0] mon_e;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [AW-1:0] low_idx(input logic [D-1:0] v);
        for (int r = 0; r < D; r++) if (v[r]) return AW'(r);
        return '0;
    endfunction

    function automatic int op_latency(input logic [2:0] op);
        case (op)
            3'd0, 3'd1: return 2 + 2 * W * 6;
            3'd2, 3'd5: return 2 + 2 * W * 1;
            3'd3:       return 2 + 2 * W * 3;
            3'd4:       return 2 + 2 * W * 2;
            3'd6:       return 3;
            default:    return 2;
        endcase
    endfunction

    // Word-level effect of an op on the reference state.
    function automatic exp_t model_op(input logic [2:0] op, input logic [W-1:0] key,
                                      input logic [W-1:0] mask);
        exp_t x;
        logic [W:0] s;
        for (int r = 0; r < D; r++) begin
            case (op)
                3'd0: begin s = {1'b0, ma[r]} + {1'b0, mb[r]}; mr[r] = s[W-1:0]; mc[r] = s[W]; end
                3'd1: begin mr[r] = ma[r] - mb[r]; mc[r] = (ma[r] >= mb[r]); end
                3'd2: begin mr[r] = ma[r] & mb[r]; mc[r] = 1'b0; end
                3'd3: begin mr[r] = ma[r] | mb[r]; mc[r] = 1'b0; end
                3'd4: begin mr[r] = ma[r] ^ mb[r]; mc[r] = 1'b0; end
                3'd5: begin mr[r] = ma[r];         mc[r] = 1'b0; end
                3'd6: mm[r] = ((ma[r] & mask) == (key & mask));
                default: ;
            endcase
        end
        x.done_cyc = '0;
        x.err      = (op == 3'd7);
        x.c        = mc;
        x.mvec     = mm;
        return x;
    endfunction

    always @(posedge clk) begin
        cyc    <= cyc + 1;
        rd_chk <= rd_issue;
    end

    // Monitor: compares whatever the DUT presents against the queues.
    always @(negedge clk) begin
        if (!rst) begin
            if (rd_chk) begin
                if (rdq.size() == 0) check("rd_unexpected", 1, 0);
                else begin
                    mon_e = rdq.pop_front();
                    check("rd_data", 64'(bus.rd_data), 64'(mon_e));
                end
            end
            if (bus.err && !bus.done) check("err_without_done", 1, 0);
            if (bus.done) begin
                if (expq.size() == 0) check("unexpected_done", 1, 0);
                else begin
                    mon_x = expq.pop_front();
                    check("done_cycle", cyc, mon_x.done_cyc);
                    check("busy_at_done", 64'(bus.busy), 1);
                    check("err", 64'(bus.err), 64'(mon_x.err));
                    check("carry_out", 64'(bus.carry_out), 64'(mon_x.c));
                    check("match_vec", 64'(bus.match_vec), 64'(mon_x.mvec));
                    check("match_any", 64'(bus.match_any), 64'(|mon_x.mvec));
                    check("match_idx", 64'(bus.match_idx), 64'(low_idx(mon_x.mvec)));
                    ops_done++;
                end
            end
        end
    end

    task automatic write_row(input logic sel, input logic [AW-1:0] addr, input logic [W-1:0] data);
        @(negedge clk);
        bus.wr_en = 1'b1; bus.wr_sel = sel; bus.wr_addr = addr; bus.wr_data = data;
        if (sel) mb[addr] = data; else ma[addr] = data;
        @(negedge clk);
        bus.wr_en = 1'b0;
    endtask

    task automatic run_op(input logic [2:0] op, input logic [W-1:0] key, input logic [W-1:0] mask,
                          input logic do_wr, input logic wsel, input logic [AW-1:0] waddr,
                          input logic [W-1:0] wdata);
        exp_t x;
        @(negedge clk);
        bus.start = 1'b1; bus.op = op; bus.key = key; bus.mask = mask;
        if (do_wr) begin
            bus.wr_en = 1'b1; bus.wr_sel = wsel; bus.wr_addr = waddr; bus.wr_data = wdata;
            if (wsel) mb[waddr] = wdata; else ma[waddr] = wdata;
        end
        x = model_op(op, key, mask);
        last_start = cyc;
        x.done_cyc = cyc + 64'(op_latency(op));
        expq.push_back(x);
        ops_issued++;
        @(negedge clk);
        bus.start = 1'b0; bus.wr_en = 1'b0;
    endtask

    task automatic wait_ops();
        int n = 0;
        while (ops_done != ops_issued && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (ops_done != ops_issued) begin
            check("op_timeout", 64'(ops_done), 64'(ops_issued));
            expq.delete();
            ops_done = ops_issued;
        end
    endtask

    task automatic read_rows(input logic [1:0] sel);
        for (int r = 0; r < D; r++) begin
            @(negedge clk);
            bus.rd_sel = sel; bus.rd_addr = AW'(r); rd_issue = 1'b1;
            case (sel)
                2'd0:    rdq.push_back(ma[r]);
                2'd1:    rdq.push_back(mb[r]);
                2'd2:    rdq.push_back(mr[r]);
                default: rdq.push_back('0);
            endcase
        end
        @(negedge clk);
        rd_issue = 1'b0;
    endtask

    task automatic model_reset();
        for (int r = 0; r < D; r++) begin ma[r] = '0; mb[r] = '0; mr[r] = '0; end
        mc = '0; mm = '0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0]    op;
        logic [W-1:0]  key, mask;
        int            row;

        rst = 1'b1;
        bus.start = 1'b0; bus.op = '0; bus.key = '0; bus.mask = '0;
        bus.wr_en = 1'b0; bus.wr_sel = 1'b0; bus.wr_addr = '0; bus.wr_data = '0;
        bus.rd_sel = '0; bus.rd_addr = '0;
        model_reset();
        repeat (3) @(negedge clk);

        // Reset state
        check("rst_busy", 64'(bus.busy), 0);
        check("rst_done", 64'(bus.done), 0);
        check("rst_err", 64'(bus.err), 0);
        check("rst_match_any", 64'(bus.match_any), 0);
        check("rst_match_vec", 64'(bus.match_vec), 0);
        check("rst_carry", 64'(bus.carry_out), 0);
        check("rst_rd_data", 64'(bus.rd_data), 0);
        rst = 1'b0;
        read_rows(2'd0); read_rows(2'd1); read_rows(2'd2);

        // ADD: 200 + 100
        write_row(1'b0, 4'd3, 8'd200);
        write_row(1'b1, 4'd3, 8'd100);
        run_op(3'd0, '0, '0, 1'b0, 1'b0, '0, '0);
        wait_ops(); read_rows(2'd2);

        // SUB with and without borrow
        write_row(1'b0, 4'd0, 8'd5); write_row(1'b1, 4'd0, 8'd9);
        write_row(1'b0, 4'd1, 8'd9); write_row(1'b1, 4'd1, 8'd5);
        run_op(3'd1, '0, '0, 1'b0, 1'b0, '0, '0);
        wait_ops(); read_rows(2'd2);

        // Logic ops on 0xC3 / 0x5A
        write_row(1'b0, 4'd0, 8'hC3); write_row(1'b1, 4'd0, 8'h5A);
        for (int k = 2; k <= 5; k++) begin
            run_op(3'(k), '0, '0, 1'b0, 1'b0, '0, '0);
            wait_ops(); read_rows(2'd2);
        end

        // SEARCH
        write_row(1'b0, 4'd2, 8'h3F); write_row(1'b0, 4'd9, 8'h3F);
        run_op(3'd6, 8'h0F, 8'h0F, 1'b0, 1'b0, '0, '0); wait_ops();
        run_op(3'd6, 8'h0F, 8'hFF, 1'b0, 1'b0, '0, '0); wait_ops();

        // Illegal op
        run_op(3'd7, '0, '0, 1'b0, 1'b0, '0, '0); wait_ops();

        // Write and start in the same cycle
        run_op(3'd0, '0, '0, 1'b1, 1'b1, 4'd5, 8'd77); wait_ops(); read_rows(2'd2);

        // Write and start while busy are both dropped
        run_op(3'd0, '0, '0, 1'b0, 1'b0, '0, '0);
        repeat (10) @(negedge clk);
        bus.wr_en = 1'b1; bus.wr_sel = 1'b0; bus.wr_addr = 4'd3; bus.wr_data = 8'h55;
        bus.start = 1'b1; bus.op = 3'd4;
        @(negedge clk);
        bus.wr_en = 1'b0; bus.start = 1'b0;
        wait_ops(); read_rows(2'd0); read_rows(2'd2);

        // Randomized ops
        for (int it = 0; it < 14; it++) begin
            for (int k = 0; k < int'($urandom_range(1, 4)); k++)
                write_row(1'($urandom_range(0, 1)), AW'($urandom_range(0, D - 1)), W'($urandom));
            op   = 3'($urandom_range(0, 7));
            row  = int'($urandom_range(0, D - 1));
            mask = W'($urandom);
            key  = ($urandom_range(0, 2) != 0) ? ma[row] : W'($urandom);
            run_op(op, key, mask, 1'b0, 1'b0, '0, '0);
            wait_ops();
            if (it % 3 == 0) read_rows(2'd2);
        end

        // Reset in the middle of an ADD
        run_op(3'd0, '0, '0, 1'b0, 1'b0, '0, '0);
        while (cyc < last_start + 64'd40) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_busy", 64'(bus.busy), 0);
        check("midrst_done", 64'(bus.done), 0);
        check("midrst_carry", 64'(bus.carry_out), 0);
        check("midrst_match_vec", 64'(bus.match_vec), 0);
        rst = 1'b0;
        expq.delete();
        ops_done = ops_issued;
        model_reset();
        read_rows(2'd2);

        // Fresh ADD after the abort
        write_row(1'b0, 4'd3, 8'd200);
        write_row(1'b1, 4'd3, 8'd100);
        run_op(3'd0, '0, '0, 1'b0, 1'b0, '0, '0);
        wait_ops(); read_rows(2'd2);

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ap_cam_engine.md
# ap_cam_engine

Parametrised bit-serial associative-processing engine that succeeds the fixed A/B/R/C/F CAM top. It holds operand arrays A and B, result array R, a per-row carry column C and a tag column. An internal pass sequencer runs ADD, SUB, AND, OR, XOR, COPY_A and a masked SEARCH across every row in parallel; the previous design needed external Pass/Key/Mask driving for this. It sits between the instruction controller (start/op/done handshake) and the data-cache loader (row write/read ports).

## Interface
Parameters:
- DATA_WIDTH, 8: bits per word (column count).
- DATA_DEPTH, 16: rows (words per array).
- ADDR_WIDTH_CAM, 4: row address width; must equal clog2(DATA_DEPTH).

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  op request; accepted only in IDLE.
- op  in  3  0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 COPY_A, 6 SEARCH, 7 illegal.
- key  in  DATA_WIDTH  SEARCH key; sampled with start.
- mask  in  DATA_WIDTH  SEARCH mask (1 = compare bit); sampled with start.
- busy  out  1  high from the cycle after acceptance through the DONE cycle.
- done  out  1  one-cycle pulse in the DONE cycle.
- err  out  1  one-cycle pulse with done when op = 7.
- wr_en  in  1  host row write.
- wr_sel  in  1  0 = A, 1 = B.
- wr_addr  in  ADDR_WIDTH_CAM  write row.
- wr_data  in  DATA_WIDTH  write data.
- rd_sel  in  2  0 = A, 1 = B, 2 = R, 3 = returns 0.
- rd_addr  in  ADDR_WIDTH_CAM  read row.
- rd_data  out  DATA_WIDTH  registered read data, 1-cycle latency.
- carry_out  out  DATA_DEPTH  C column (carry for ADD; for SUB, 1 = no borrow).
- match_vec  out  DATA_DEPTH  SEARCH result per row.
- match_any  out  1  OR of match_vec.
- match_idx  out  ADDR_WIDTH_CAM  lowest matching row index; 0 if none.

## Operation
- Reset state: A, B, R, C, tag, match_vec and rd_data are 0. busy, done, err and match_any are 0. FSM is in IDLE.
- FSM states and transitions:
  - IDLE → INIT when start is accepted.
  - INIT → CMP for arithmetic/logic ops; INIT → SRCH for SEARCH; INIT → DONE for op 7.
  - CMP ↔ WR alternate for each pass.
  - SRCH → DONE.
  - DONE → IDLE.
- Op, key and mask are latched on acceptance.
- INIT for ADD, AND, OR, XOR, COPY_A: R ← 0, C ← 0. For SUB: R ← 0, C ← all ones. For SEARCH and op 7: no array change.
- Bit loop: bit index i runs 0 to DATA_WIDTH−1 (LSB first). Pass index p runs 0 to NPASS(op)−1. p wraps to 0 and i increments after the last pass.
- CMP cycle: tag[r] ← (masked match of {C[r], A[r][i], B'[r][i]} against the pass key). B' = ~B for SUB, B otherwise.
- WR cycle: for every row with tag set, apply the pass write: either R[r][i] ← 1, or C[r] ← value.
- Pass tables, key written as {C,A,B}, x = masked:
  - ADD/SUB, 6 passes:
    - p0–p3 set R to 1 for keys 001, 010, 100, 111.
    - p4 key 100 writes C ← 0.
    - p5 key 011 writes C ← 1.
    - All sum passes precede carry passes, so every sum uses the pre-update carry.
  - AND, 1 pass: key x11.
  - OR, 3 passes: keys x10, x01, x11.
  - XOR, 2 passes: keys x10, x01.
  - COPY_A, 1 pass: key x1x.
  - Logic ops never write C.
- Result arithmetic: R = (A + B) mod 2^DATA_WIDTH, or (A − B) mod 2^DATA_WIDTH. The final C is the carry / not-borrow.
- SEARCH: match_vec[r] ← &(~(A[r] ^ key) | ~mask). Then match_any and match_idx follow. match_vec changes only on SEARCH or rst.
- Host port:
  - wr_en is honoured only in IDLE, including the acceptance cycle. A simultaneous write and start means the op sees the new data.
  - wr_en is silently dropped while busy.
  - Reads are allowed in any state. R read mid-op returns partial results.
- start while busy: ignored.
- rst mid-op: aborts the op. Everything returns to reset values; no done pulse.

## Timing
- start sampled in cycle 0 → INIT in cycle 1.
- Arithmetic/logic: CMP/WR run in cycles 2 through 1+2·DATA_WIDTH·NPASS. done is in cycle 2+2·DATA_WIDTH·NPASS. For ADD at W=8 this is cycle 98.
- SEARCH: SRCH in cycle 2, done in cycle 3. match_vec is valid from cycle 3.
- Op 7: done and err in cycle 2; no state change.
- Next start is accepted in the cycle after done.
- rd_data reflects array contents at the rd_addr edge, one cycle later.

## Structure
- Package ap_pkg holds:
  - opcode localparams;
  - NPASS per op;
  - FSM state enum;
  - pass-entry field widths (key[2:0], keymask[2:0], wr_r, wr_c_en, wr_c_val).
- Sub-module ap_pass_rom: combinational (op, p) → pass entry. Keeps the truth tables out of the datapath.
- A separate priority encoder is not needed. It is an inline for-loop.

## Test plan
- W=8: A[3]=200, B[3]=100, ADD → done at cycle 98, R[3]=44, carry_out[3]=1. Rows left at 0 give R=0, C=0.
- SUB: A[0]=5, B[0]=9 → R[0]=252, carry_out[0]=0. A[1]=9, B[1]=5 → R[1]=4, carry_out[1]=1.
- Logic ops: A=0xC3, B=0x5A → AND 0x42 (done cycle 18), OR 0xDB (done cycle 50), XOR 0x99 (done cycle 34), COPY_A 0xC3 (done cycle 18).
- SEARCH: A rows 2 and 9 = 0x3F, key 0x0F, mask 0x0F → match_vec bits 2 and 9 set, match_idx 2 at cycle 3. With mask 0xFF → match_any 0.
- Host-port hazards:
  - wr_en with start in the same cycle: the op uses the written value.
  - wr_en during busy: dropped.
  - start during busy: ignored.
  - op 7: err and done at cycle 2.
- rst asserted at cycle 40 of an ADD → next cycle busy=0, R=0, C=0, no done. A fresh ADD afterwards completes at cycle 98.
